// File: rtl/arp_cache_pkg.sv
// arp_cache_pkg: shared widths and controller state encoding for the
// multi-entry ARP cache (arp_cache_table).
package arp_cache_pkg;

  localparam int unsigned IP_W  = 32;
  localparam int unsigned MAC_W = 48;

  typedef enum logic [1:0] {
    IDLE,
    LKP_SCAN,
    LRN_SCAN,
    LRN_WRITE
  } state_t;

endpackage

// File: rtl/arp_cache_table.sv
// arp_cache_table: multi-entry IP->MAC cache with aging, refresh on relearn,
// oldest-entry replacement and flush. gmii_tx_clk domain.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               pulse, invalidate all entries / abort current scan
//   age_tick            pulse, decrement age of every valid entry
//   learn_valid/ip/mac  learn request from the ARP receive path
//   learn_drop          pulse, a pending learn was overwritten
//   lookup_req/ip       lookup request, accepted when lookup_ready=1
//   lookup_ready        block can accept a lookup
//   lookup_done         one-cycle result strobe
//   lookup_hit/mac      result, held until the next lookup_done
//   entry_count         registered number of valid entries
module arp_cache_table
  import arp_cache_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned AGE_W   = 8,
  parameter int unsigned AGE_MAX = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         age_tick,
  input  logic                         learn_valid,
  input  logic [IP_W-1:0]              learn_ip,
  input  logic [MAC_W-1:0]             learn_mac,
  output logic                         learn_drop,
  input  logic                         lookup_req,
  input  logic [IP_W-1:0]              lookup_ip,
  output logic                         lookup_ready,
  output logic                         lookup_done,
  output logic                         lookup_hit,
  output logic [MAC_W-1:0]             lookup_mac,
  output logic [$clog2(ENTRIES+1)-1:0] entry_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
  localparam logic [AGE_W-1:0] AGE_LOAD  = AGE_W'(AGE_MAX);
  localparam logic [CNT_W-1:0] IDX_LAST  = CNT_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] IDX_END   = CNT_W'(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
    logic [AGE_W-1:0] age;
  } entry_t;

  entry_t           ent_q [ENTRIES];

  state_t           state_q;
  logic [CNT_W-1:0] scan_idx;
  logic [IDX_W-1:0] cur_idx;
  entry_t           cur;

  logic             pend_valid;
  logic [IP_W-1:0]  pend_ip;
  logic [MAC_W-1:0] pend_mac;

  logic [IP_W-1:0]  req_ip;
  logic             lkp_found;
  logic [MAC_W-1:0] lkp_mac_q;

  logic [IP_W-1:0]  lrn_ip;
  logic [MAC_W-1:0] lrn_mac;
  logic             m_found, f_found, v_found;
  logic [IDX_W-1:0] m_idx, f_idx, v_idx;
  logic [AGE_W-1:0] v_age;

  logic             learn_in;
  logic             take_pend;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] valid_cnt;

  assign lookup_ready = (state_q == IDLE) && !pend_valid;
  assign learn_in     = learn_valid && (learn_ip != '0);
  assign take_pend    = (state_q == IDLE) && pend_valid && !flush;
  assign wr_en        = (state_q == LRN_WRITE) && !flush;

  // Guard the extra result cycle of the lookup scan (scan_idx == ENTRIES).
  always_comb begin
    cur_idx = '0;
    if (scan_idx < IDX_END) cur_idx = scan_idx[IDX_W-1:0];
    cur = ent_q[cur_idx];
  end

  always_comb begin
    wr_idx = v_idx;
    if (m_found)      wr_idx = m_idx;
    else if (f_found) wr_idx = f_idx;
  end

  always_comb begin
    valid_cnt = '0;
    for (int unsigned i = 0; i < ENTRIES; i++)
      valid_cnt = valid_cnt + CNT_W'(ent_q[i].valid);
  end

  // Entry storage: flush beats a learn write, a learn write beats aging.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (flush) begin
          ent_q[i].valid <= 1'b0;
        end else if (wr_en && (wr_idx == IDX_W'(i))) begin
          ent_q[i] <= '{valid: 1'b1, ip: lrn_ip, mac: lrn_mac, age: AGE_LOAD};
        end else if (age_tick && ent_q[i].valid) begin
          ent_q[i].age <= ent_q[i].age - AGE_W'(1);
          if (ent_q[i].age == AGE_W'(1)) ent_q[i].valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_idx    <= '0;
      pend_valid  <= 1'b0;
      pend_ip     <= '0;
      pend_mac    <= '0;
      req_ip      <= '0;
      lkp_found   <= 1'b0;
      lkp_mac_q   <= '0;
      lrn_ip      <= '0;
      lrn_mac     <= '0;
      m_found     <= 1'b0;
      f_found     <= 1'b0;
      v_found     <= 1'b0;
      m_idx       <= '0;
      f_idx       <= '0;
      v_idx       <= '0;
      v_age       <= '0;
      learn_drop  <= 1'b0;
      lookup_done <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_mac  <= '0;
      entry_count <= '0;
    end else begin
      lookup_done <= 1'b0;
      learn_drop  <= 1'b0;
      entry_count <= valid_cnt;

      // A pending learn consumed this cycle is not counted as dropped.
      if (flush) begin
        pend_valid <= 1'b0;
      end else if (learn_in) begin
        pend_valid <= 1'b1;
        pend_ip    <= learn_ip;
        pend_mac   <= learn_mac;
        learn_drop <= pend_valid && !take_pend;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end

      if (flush) begin
        state_q <= IDLE;
        if (state_q == LKP_SCAN) begin
          lookup_done <= 1'b1;
          lookup_hit  <= 1'b0;
          lookup_mac  <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (pend_valid) begin
              lrn_ip   <= pend_ip;
              lrn_mac  <= pend_mac;
              m_found  <= 1'b0;
              f_found  <= 1'b0;
              v_found  <= 1'b0;
              scan_idx <= '0;
              state_q  <= LRN_SCAN;
            end else if (lookup_req) begin
              req_ip    <= lookup_ip;
              lkp_found <= 1'b0;
              lkp_mac_q <= '0;
              scan_idx  <= '0;
              state_q   <= LKP_SCAN;
            end
          end
          LKP_SCAN: begin
            if (scan_idx == IDX_END) begin
              lookup_done <= 1'b1;
              lookup_hit  <= lkp_found;
              lookup_mac  <= lkp_mac_q;
              state_q     <= IDLE;
            end else begin
              if (!lkp_found && cur.valid && (cur.ip == req_ip)) begin
                lkp_found <= 1'b1;
                lkp_mac_q <= cur.mac;
              end
              scan_idx <= scan_idx + CNT_W'(1);
            end
          end
          LRN_SCAN: begin
            if (!m_found && cur.valid && (cur.ip == lrn_ip)) begin
              m_found <= 1'b1;
              m_idx   <= cur_idx;
            end
            if (!f_found && !cur.valid) begin
              f_found <= 1'b1;
              f_idx   <= cur_idx;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (cur.valid && (!v_found || (cur.age < v_age))) begin
              v_found <= 1'b1;
              v_idx   <= cur_idx;
              v_age   <= cur.age;
            end
            if (scan_idx == IDX_LAST) state_q <= LRN_WRITE;
            scan_idx <= scan_idx + CNT_W'(1);
          end
          LRN_WRITE: state_q <= IDLE;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arp_cache_table.sv
// tb_arp_cache_table: directed self-checking bench for arp_cache_table
// (ENTRIES=4, AGE_MAX=3).
module tb_arp_cache_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        age_tick = 1'b0;
  logic        learn_valid = 1'b0;
  logic [31:0] learn_ip = '0;
  logic [47:0] learn_mac = '0;
  logic        learn_drop;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_ip = '0;
  logic        lookup_ready;
  logic        lookup_done;
  logic        lookup_hit;
  logic [47:0] lookup_mac;
  logic [2:0]  entry_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  arp_cache_table #(.ENTRIES(4), .AGE_W(8), .AGE_MAX(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .age_tick     (age_tick),
    .learn_valid  (learn_valid),
    .learn_ip     (learn_ip),
    .learn_mac    (learn_mac),
    .learn_drop   (learn_drop),
    .lookup_req   (lookup_req),
    .lookup_ip    (lookup_ip),
    .lookup_ready (lookup_ready),
    .lookup_done  (lookup_done),
    .lookup_hit   (lookup_hit),
    .lookup_mac   (lookup_mac),
    .entry_count  (entry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!lookup_ready && n < 30) begin
      step();
      n++;
    end
    check({tag, "_ready"}, lookup_ready, 1);
  endtask

  task automatic do_learn(input logic [31:0] ip, input logic [47:0] mac);
    learn_valid = 1'b1;
    learn_ip    = ip;
    learn_mac   = mac;
    step();
    learn_valid = 1'b0;
    wait_ready("learn");
  endtask

  task automatic do_tick();
    age_tick = 1'b1;
    step();
    age_tick = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] ip,
                           input logic exp_hit, input logic [47:0] exp_mac);
    int unsigned lat;
    wait_ready(tag);
    lookup_req = 1'b1;
    lookup_ip  = ip;
    step();
    lookup_req = 1'b0;
    lat = 0;
    while (!lookup_done && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 5);
    check({tag, "_hit"}, lookup_hit, exp_hit);
    check({tag, "_mac"}, lookup_mac, exp_mac);
  endtask

  initial begin
    int unsigned drops;
    int unsigned dones;

    // Reset values
    step();
    step();
    check("rst_ready", lookup_ready, 1);
    check("rst_done", lookup_done, 0);
    check("rst_hit", lookup_hit, 0);
    check("rst_mac", lookup_mac, 0);
    check("rst_drop", learn_drop, 0);
    check("rst_count", entry_count, 0);
    rst = 1'b0;
    step();

    // 1. Cold lookup
    do_lookup("cold", 32'hC0A8_0002, 1'b0, 48'h0);
    check("cold_count", entry_count, 0);

    // 2. Learn then hit
    learn_valid = 1'b1;
    learn_ip    = 32'hC0A8_0002;
    learn_mac   = 48'h000A_3501_FEC0;
    step();
    learn_valid = 1'b0;
    check("learn_busy", lookup_ready, 0);
    wait_ready("learn2");
    step();
    check("learn_count", entry_count, 1);
    do_lookup("hit2", 32'hC0A8_0002, 1'b1, 48'h000A_3501_FEC0);

    // 3. Fill, age out .1 into a free slot
    flush = 1'b1;
    step();
    flush = 1'b0;
    do_learn(32'hC0A8_0001, 48'h000A_3500_0001);
    do_tick();
    do_learn(32'hC0A8_0002, 48'h000A_3500_0002);
    do_tick();
    do_learn(32'hC0A8_0003, 48'h000A_3500_0003);
    do_tick();
    do_learn(32'hC0A8_0004, 48'h000A_3500_0004);
    do_learn(32'hC0A8_0005, 48'h000A_3500_0005);
    step();
    check("fill_count", entry_count, 4);
    do_lookup("ev1", 32'hC0A8_0001, 1'b0, 48'h0);
    do_lookup("hit5", 32'hC0A8_0005, 1'b1, 48'h000A_3500_0005);

    // 4. Relearn .2 refreshes age; .6 then evicts .3 (oldest)
    do_learn(32'hC0A8_0002, 48'h000A_3501_FEC1);
    step();
    check("relearn_count", entry_count, 4);
    do_lookup("relearn", 32'hC0A8_0002, 1'b1, 48'h000A_3501_FEC1);
    do_learn(32'hC0A8_0006, 48'h000A_3500_0006);
    step();
    check("victim_count", entry_count, 4);
    do_lookup("ev3", 32'hC0A8_0003, 1'b0, 48'h0);
    do_lookup("keep2", 32'hC0A8_0002, 1'b1, 48'h000A_3501_FEC1);
    do_lookup("hit6", 32'hC0A8_0006, 1'b1, 48'h000A_3500_0006);
    do_lookup("keep4", 32'hC0A8_0004, 1'b1, 48'h000A_3500_0004);

    // 5. Aging
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("flush_count", entry_count, 0);
    learn_valid = 1'b1;
    learn_ip    = 32'h0;
    learn_mac   = 48'h1;
    step();
    learn_valid = 1'b0;
    check("zero_ip_ignored", lookup_ready, 1);
    do_learn(32'hC0A8_0007, 48'h000A_3500_0007);
    do_tick();
    do_tick();
    do_tick();
    check("age_count_lag", entry_count, 1);
    step();
    check("age_count", entry_count, 0);
    do_lookup("aged", 32'hC0A8_0007, 1'b0, 48'h0);

    do_learn(32'hC0A8_0008, 48'h000A_3500_0008);
    do_tick();
    do_tick();
    learn_valid = 1'b1;
    learn_ip    = 32'hC0A8_0008;
    learn_mac   = 48'h000A_3500_0088;
    step();
    learn_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    do_tick();
    check("tick_write_ready", lookup_ready, 1);
    step();
    check("tick_write_count", entry_count, 1);
    do_tick();
    do_lookup("tick_write", 32'hC0A8_0008, 1'b1, 48'h000A_3500_0088);

    // 6a. Flush mid-lookup
    wait_ready("fl");
    lookup_req = 1'b1;
    lookup_ip  = 32'hC0A8_0008;
    step();
    lookup_req = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_done", lookup_done, 1);
    check("flush_hit", lookup_hit, 0);
    check("flush_mac", lookup_mac, 0);
    step();
    check("flush_done_clr", lookup_done, 0);
    check("flush_count0", entry_count, 0);

    // 6b. Three learns during a lookup: two drops, last one kept
    wait_ready("drop");
    lookup_req = 1'b1;
    lookup_ip  = 32'hC0A8_0009;
    step();
    lookup_req = 1'b0;
    drops = 0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      learn_valid = (i < 3);
      learn_ip    = 32'hC0A8_000A + i;
      learn_mac   = 48'h000A_3500_000A + i;
      step();
      if (learn_drop) drops++;
      if (lookup_done) dones++;
    end
    learn_valid = 1'b0;
    check("drop_pulses", drops, 2);
    check("drop_lkp_done", dones, 1);
    check("drop_lkp_hit", lookup_hit, 0);
    wait_ready("drop_learn");
    step();
    check("drop_count", entry_count, 1);
    do_lookup("dropA", 32'hC0A8_000A, 1'b0, 48'h0);
    do_lookup("dropB", 32'hC0A8_000B, 1'b0, 48'h0);
    do_lookup("keepC", 32'hC0A8_000C, 1'b1, 48'h000A_3500_000C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
